// File: rtl/sprite_write_pkg.sv
// Shared constants, the engine state type and the frame-buffer index helper.
package sprite_write_pkg;

   localparam int H_RES       = 640;
   localparam int V_RES       = 480;
   localparam int ADDR_W      = 18;
   localparam int PIX_W       = 4;
   localparam int TRANSPARENT = 0;
   localparam int BG_COLOR    = 0;
   localparam int FB_ADDR_W   = 19;
   localparam int COORD_W     = 10;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } state_t;

   // Linear frame-buffer index y*h_res + x, evaluated at full 19-bit width.
   function automatic logic [FB_ADDR_W-1:0] fb_index(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input int                 h_res
   );
      logic [FB_ADDR_W-1:0] x_ext;
      logic [FB_ADDR_W-1:0] y_ext;
      logic [FB_ADDR_W-1:0] h_ext;
      x_ext = FB_ADDR_W'(x);
      y_ext = FB_ADDR_W'(y);
      h_ext = FB_ADDR_W'(h_res);
      return y_ext * h_ext + x_ext;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter: steps X across a line, wraps into the next row,
// and flags the final pixel of the frame.
module raster_counter
   import sprite_write_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               enable,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last_pixel
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] x_d;
   logic [COORD_W-1:0] y_q;
   logic [COORD_W-1:0] y_d;

   // Next position: hold when disabled, wrap column then row at the frame end.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (enable) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
               y_d = '0;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/sprite_write_engine.sv
// Frame-buffer write engine: scans one frame, picks the highest-priority
// sprite layer per pixel, fetches its palette index from the sprite ROM and
// streams the pixels to the frame buffer under a ready handshake.
module sprite_write_engine
   import sprite_write_pkg::*;
#(
   parameter int H_RES       = sprite_write_pkg::H_RES,
   parameter int V_RES       = sprite_write_pkg::V_RES,
   parameter int LAYERS      = 4,
   parameter int ROM_LAT     = 2,
   parameter int ADDR_W      = sprite_write_pkg::ADDR_W,
   parameter int PIX_W       = sprite_write_pkg::PIX_W,
   parameter int TRANSPARENT = sprite_write_pkg::TRANSPARENT,
   parameter int BG_COLOR    = sprite_write_pkg::BG_COLOR
) (
   input  logic                     Clk50,
   input  logic                     Reset_n,
   input  logic                     frame_start,
   output logic [COORD_W-1:0]       WriteX,
   output logic [COORD_W-1:0]       WriteY,
   input  logic [LAYERS-1:0]        layer_on,
   input  logic [LAYERS*ADDR_W-1:0] layer_addr,
   output logic [ADDR_W-1:0]        rom_addr,
   output logic                     rom_en,
   input  logic [PIX_W-1:0]         rom_data,
   output logic                     fb_we,
   output logic [FB_ADDR_W-1:0]     fb_addr,
   output logic [PIX_W-1:0]         fb_data,
   input  logic                     fb_ready,
   output logic                     busy,
   output logic                     frame_done
);

   state_t state_q;
   state_t state_d;

   logic               adv;
   logic               scan_active;
   logic               pipe_busy;
   logic               cnt_clear;
   logic               cnt_enable;
   logic               last_pixel;
   logic [COORD_W-1:0] cnt_x;
   logic [COORD_W-1:0] cnt_y;

   logic               s1_valid_q;
   logic               s1_valid_d;
   logic               s1_hit_q;
   logic               s1_hit_d;
   logic [COORD_W-1:0] s1_x_q;
   logic [COORD_W-1:0] s1_x_d;
   logic [COORD_W-1:0] s1_y_q;
   logic [COORD_W-1:0] s1_y_d;
   logic [ADDR_W-1:0]  rom_addr_q;
   logic [ADDR_W-1:0]  rom_addr_d;

   logic [ROM_LAT-1:0]              dl_valid_q;
   logic [ROM_LAT-1:0]              dl_valid_d;
   logic [ROM_LAT-1:0]              dl_hit_q;
   logic [ROM_LAT-1:0]              dl_hit_d;
   logic [ROM_LAT-1:0][COORD_W-1:0] dl_x_q;
   logic [ROM_LAT-1:0][COORD_W-1:0] dl_x_d;
   logic [ROM_LAT-1:0][COORD_W-1:0] dl_y_q;
   logic [ROM_LAT-1:0][COORD_W-1:0] dl_y_d;

   logic               out_valid;
   logic               out_hit;
   logic [COORD_W-1:0] out_x;
   logic [COORD_W-1:0] out_y;

   assign out_valid   = dl_valid_q[ROM_LAT-1];
   assign out_hit     = dl_hit_q[ROM_LAT-1];
   assign out_x       = dl_x_q[ROM_LAT-1];
   assign out_y       = dl_y_q[ROM_LAT-1];
   assign adv         = !(out_valid && !fb_ready);
   assign scan_active = (state_q == SCAN);
   assign pipe_busy   = s1_valid_q || (|dl_valid_q);
   assign cnt_clear   = (state_q == IDLE);
   assign cnt_enable  = scan_active && adv;

   raster_counter #(
      .H_RES(H_RES),
      .V_RES(V_RES)
   ) u_raster (
      .clk       (Clk50),
      .rst_n     (Reset_n),
      .clear     (cnt_clear),
      .enable    (cnt_enable),
      .x         (cnt_x),
      .y         (cnt_y),
      .last_pixel(last_pixel)
   );

   // Frame sequencing: scan every pixel, then wait for the pipeline to empty.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_start) state_d = SCAN;
         SCAN:    if (adv && last_pixel) state_d = DRAIN;
         DRAIN:   if (!pipe_busy) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Priority select: the lowest-numbered layer that is on supplies the ROM address.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_hit_d   = s1_hit_q;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      rom_addr_d = rom_addr_q;
      if (adv) begin
         s1_valid_d = scan_active;
         s1_x_d     = cnt_x;
         s1_y_d     = cnt_y;
         s1_hit_d   = 1'b0;
         for (int i = LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) begin
               s1_hit_d   = 1'b1;
               rom_addr_d = layer_addr[i*ADDR_W +: ADDR_W];
            end
         end
      end
   end

   // Delay line that keeps pixel coordinates and flags aligned with rom_data.
   always_comb begin
      dl_valid_d = dl_valid_q;
      dl_hit_d   = dl_hit_q;
      dl_x_d     = dl_x_q;
      dl_y_d     = dl_y_q;
      if (adv) begin
         dl_valid_d[0] = s1_valid_q;
         dl_hit_d[0]   = s1_hit_q;
         dl_x_d[0]     = s1_x_q;
         dl_y_d[0]     = s1_y_q;
         for (int i = 1; i < ROM_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_hit_d[i]   = dl_hit_q[i-1];
            dl_x_d[i]     = dl_x_q[i-1];
            dl_y_d[i]     = dl_y_q[i-1];
         end
      end
   end

   // State, select stage and delay-line registers; reset empties the pipeline.
   always_ff @(posedge Clk50 or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         s1_valid_q <= 1'b0;
         s1_hit_q   <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         rom_addr_q <= '0;
         dl_valid_q <= '0;
         dl_hit_q   <= '0;
         dl_x_q     <= '0;
         dl_y_q     <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_hit_q   <= s1_hit_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         rom_addr_q <= rom_addr_d;
         dl_valid_q <= dl_valid_d;
         dl_hit_q   <= dl_hit_d;
         dl_x_q     <= dl_x_d;
         dl_y_q     <= dl_y_d;
      end
   end

   // Pixel colour: background unless an opaque sprite texel covers the pixel.
   always_comb begin
      fb_data = PIX_W'(BG_COLOR);
      if (out_hit && (rom_data != PIX_W'(TRANSPARENT))) begin
         fb_data = rom_data;
      end
   end

   assign WriteX     = cnt_x;
   assign WriteY     = cnt_y;
   assign rom_addr   = rom_addr_q;
   assign busy       = (state_q == SCAN) || (state_q == DRAIN);
   assign rom_en     = adv && busy;
   assign fb_we      = out_valid;
   assign fb_addr    = fb_index(out_x, out_y, H_RES);
   assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_sprite_write_engine.sv
// Directed bench for sprite_write_engine on a reduced 64x48 raster.
module tb_sprite_write_engine;

   localparam int H_RES   = 64;
   localparam int V_RES   = 48;
   localparam int LAYERS  = 4;
   localparam int ROM_LAT = 2;
   localparam int ADDR_W  = 18;
   localparam int PIX_W   = 4;
   localparam int NPIX    = H_RES * V_RES;

   logic                     Clk50 = 1'b0;
   logic                     Reset_n = 1'b0;
   logic                     frame_start = 1'b0;
   logic [9:0]               WriteX;
   logic [9:0]               WriteY;
   logic [LAYERS-1:0]        layer_on;
   logic [LAYERS*ADDR_W-1:0] layer_addr;
   logic [ADDR_W-1:0]        rom_addr;
   logic                     rom_en;
   logic [PIX_W-1:0]         rom_data;
   logic                     fb_we;
   logic [18:0]              fb_addr;
   logic [PIX_W-1:0]         fb_data;
   logic                     fb_ready = 1'b1;
   logic                     busy;
   logic                     frame_done;
   logic                     sprite_mode = 1'b0;

   int assertions = 0;
   int failures   = 0;

   sprite_write_engine #(
      .H_RES(H_RES), .V_RES(V_RES), .LAYERS(LAYERS), .ROM_LAT(ROM_LAT),
      .ADDR_W(ADDR_W), .PIX_W(PIX_W), .TRANSPARENT(0), .BG_COLOR(0)
   ) dut (
      .Clk50(Clk50), .Reset_n(Reset_n), .frame_start(frame_start),
      .WriteX(WriteX), .WriteY(WriteY), .layer_on(layer_on), .layer_addr(layer_addr),
      .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 Clk50 = ~Clk50;

   // Layer model: sprite on layer 0, plus two overlapping-layer pixels on row 20.
   always_comb begin
      layer_on   = '0;
      layer_addr = '0;
      if (sprite_mode) begin
         if (WriteX >= 10'd10 && WriteX <= 10'd27 && WriteY >= 10'd5 && WriteY <= 10'd14) begin
            layer_on[0]          = 1'b1;
            layer_addr[0 +: 18]  = 18'(1000 + (int'(WriteY) - 5) * 18 + (int'(WriteX) - 10));
         end
         if (WriteX == 10'd40 && WriteY == 10'd20) begin
            layer_on[0]          = 1'b1;
            layer_addr[0 +: 18]  = 18'd2000;
            layer_on[2]          = 1'b1;
            layer_addr[36 +: 18] = 18'd3001;
         end
         if (WriteX == 10'd41 && WriteY == 10'd20) begin
            layer_on[1]          = 1'b1;
            layer_addr[18 +: 18] = 18'd4005;
            layer_on[3]          = 1'b1;
            layer_addr[54 +: 18] = 18'd4003;
         end
      end
   end

   // Sprite ROM model: data = addr[3:0], two enabled cycles of latency.
   logic [PIX_W-1:0] rom_stage;
   always @(posedge Clk50 or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_stage <= '0;
         rom_data  <= '0;
      end else if (rom_en) begin
         rom_stage <= rom_addr[3:0];
         rom_data  <= rom_stage;
      end
   end

   // Frame-buffer model: records accepted writes and raster-order breaks.
   int               write_count  = 0;
   int               order_errors = 0;
   int               done_count   = 0;
   int               expected_next = 0;
   int               last_addr    = -1;
   logic [PIX_W-1:0] fb_mem [NPIX];
   logic             pri_pending  = 1'b0;
   logic [ADDR_W-1:0] pri_rom_addr = '0;

   always @(negedge Clk50) begin
      if (pri_pending) begin
         pri_rom_addr = rom_addr;
         pri_pending  = 1'b0;
      end
      if (busy && WriteX == 10'd40 && WriteY == 10'd20) pri_pending = 1'b1;
      if (frame_done) done_count++;
      if (Reset_n && fb_we && fb_ready) begin
         if (int'(fb_addr) != expected_next && fb_addr != 19'd0) order_errors++;
         expected_next = int'(fb_addr) + 1;
         last_addr     = int'(fb_addr);
         write_count++;
         if (int'(fb_addr) < NPIX) fb_mem[int'(fb_addr)] = fb_data;
      end
   end

   task automatic start_frame();
      @(posedge Clk50);
      #1 frame_start = 1'b1;
      @(posedge Clk50);
      #1 frame_start = 1'b0;
   endtask

   task automatic wait_done(input int base_d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < NPIX + 200; i++) begin
         @(negedge Clk50);
         if (done_count > base_d) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (4) @(negedge Clk50);
   endtask

   task automatic wait_accept(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < NPIX + 200; i++) begin
         @(negedge Clk50);
         if (fb_we && fb_ready && int'(fb_addr) == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk50);
      assertions++;
      if ({WriteX, WriteY} !== 20'd0) begin
         failures++; $display("[TB] FAIL reset_xy: got %h, expected 0", {WriteX, WriteY});
      end
      assertions++;
      if ({fb_we, fb_addr, fb_data} !== 24'd0) begin
         failures++; $display("[TB] FAIL reset_fb: got %h, expected 0", {fb_we, fb_addr, fb_data});
      end
      assertions++;
      if ({rom_addr, rom_en, busy, frame_done} !== 21'd0) begin
         failures++; $display("[TB] FAIL reset_ctrl: got %h, expected 0", {rom_addr, rom_en, busy, frame_done});
      end
      @(posedge Clk50);
      #1 Reset_n = 1'b1;
   endtask

   task automatic test_idle();
      int busy_seen = 0;
      int we_seen   = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk50);
         if (busy) busy_seen++;
         if (fb_we) we_seen++;
      end
      assertions++;
      if (we_seen != 0) begin
         failures++; $display("[TB] FAIL idle_we: got %0d cycles with fb_we, expected 0", we_seen);
      end
      assertions++;
      if (busy_seen != 0) begin
         failures++; $display("[TB] FAIL idle_busy: got %0d busy cycles, expected 0", busy_seen);
      end
   endtask

   task automatic test_background_frame();
      int base_w, base_o, base_d;
      bit ok;
      sprite_mode = 1'b0;
      base_w = write_count; base_o = order_errors; base_d = done_count;
      start_frame();
      @(negedge Clk50);
      assertions++;
      if (busy !== 1'b1 || WriteX !== 10'd0 || WriteY !== 10'd0) begin
         failures++; $display("[TB] FAIL scan_start: busy=%b x=%0d y=%0d, expected 1,0,0", busy, WriteX, WriteY);
      end
      repeat (2) @(negedge Clk50);
      assertions++;
      if (fb_we !== 1'b0) begin
         failures++; $display("[TB] FAIL latency_early: fb_we=%b, expected 0", fb_we);
      end
      @(negedge Clk50);
      assertions++;
      if (fb_we !== 1'b1 || fb_addr !== 19'd0 || fb_data !== 4'd0) begin
         failures++; $display("[TB] FAIL first_write: we=%b addr=%0d data=%0d, expected 1,0,0", fb_we, fb_addr, fb_data);
      end
      wait_done(base_d, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL bg_timeout: frame_done not seen, expected a pulse");
      end
      assertions++;
      if (write_count - base_w != NPIX || last_addr != NPIX - 1) begin
         failures++; $display("[TB] FAIL bg_count: writes=%0d last=%0d, expected %0d,%0d", write_count - base_w, last_addr, NPIX, NPIX - 1);
      end
      assertions++;
      if (order_errors != base_o) begin
         failures++; $display("[TB] FAIL bg_order: got %0d order breaks, expected 0", order_errors - base_o);
      end
      assertions++;
      if (done_count - base_d != 1 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL bg_done: pulses=%0d busy=%b, expected 1,0", done_count - base_d, busy);
      end
   endtask

   task automatic test_sprite_priority();
      int base_w, base_d;
      bit ok;
      sprite_mode = 1'b1;
      base_w = write_count; base_d = done_count;
      start_frame();
      wait_done(base_d, ok);
      assertions++;
      if (!ok || write_count - base_w != NPIX) begin
         failures++; $display("[TB] FAIL sprite_count: done=%b writes=%0d, expected 1,%0d", ok, write_count - base_w, NPIX);
      end
      assertions++;
      if (fb_mem[330] !== 4'd8) begin
         failures++; $display("[TB] FAIL sprite_corner: got %0d, expected 8", fb_mem[330]);
      end
      assertions++;
      if (fb_mem[329] !== 4'd0) begin
         failures++; $display("[TB] FAIL sprite_left_bg: got %0d, expected 0", fb_mem[329]);
      end
      assertions++;
      if (fb_mem[660] !== 4'd12) begin
         failures++; $display("[TB] FAIL sprite_mid: got %0d, expected 12", fb_mem[660]);
      end
      assertions++;
      if (fb_mem[923] !== 4'd11 || fb_mem[924] !== 4'd0) begin
         failures++; $display("[TB] FAIL sprite_edge: got %0d,%0d, expected 11,0", fb_mem[923], fb_mem[924]);
      end
      assertions++;
      if (pri_rom_addr !== 18'd2000) begin
         failures++; $display("[TB] FAIL priority_addr: got %0d, expected 2000", pri_rom_addr);
      end
      assertions++;
      if (fb_mem[1320] !== 4'd0) begin
         failures++; $display("[TB] FAIL transparent: got %0d, expected 0", fb_mem[1320]);
      end
      assertions++;
      if (fb_mem[1321] !== 4'd5) begin
         failures++; $display("[TB] FAIL priority_data: got %0d, expected 5", fb_mem[1321]);
      end
   endtask

   task automatic test_stall();
      int base_w, base_o, base_d;
      bit ok;
      sprite_mode = 1'b1;
      base_w = write_count; base_o = order_errors; base_d = done_count;
      start_frame();
      wait_accept(659, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL stall_reach: address 659 never written, expected it");
      end
      @(posedge Clk50);
      #1 fb_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk50);
         assertions++;
         if (fb_we !== 1'b1 || fb_addr !== 19'd660 || fb_data !== 4'd12 || rom_en !== 1'b0) begin
            failures++; $display("[TB] FAIL stall_hold: we=%b addr=%0d data=%0d rom_en=%b, expected 1,660,12,0", fb_we, fb_addr, fb_data, rom_en);
         end
      end
      @(posedge Clk50);
      #1 fb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk50);
         assertions++;
         if (fb_we !== 1'b1 || int'(fb_addr) != 660 + i) begin
            failures++; $display("[TB] FAIL stall_resume: we=%b addr=%0d, expected 1,%0d", fb_we, fb_addr, 660 + i);
         end
      end
      wait_done(base_d, ok);
      assertions++;
      if (!ok || write_count - base_w != NPIX || order_errors != base_o) begin
         failures++; $display("[TB] FAIL stall_count: done=%b writes=%0d breaks=%0d, expected 1,%0d,0", ok, write_count - base_w, order_errors - base_o, NPIX);
      end
   endtask

   task automatic test_overrun();
      int base_w, base_o, base_d;
      bit ok;
      sprite_mode = 1'b0;
      base_w = write_count; base_o = order_errors; base_d = done_count;
      start_frame();
      repeat (200) @(negedge Clk50);
      start_frame();
      wait_done(base_d, ok);
      assertions++;
      if (!ok || write_count - base_w != NPIX || order_errors != base_o) begin
         failures++; $display("[TB] FAIL overrun_count: done=%b writes=%0d breaks=%0d, expected 1,%0d,0", ok, write_count - base_w, order_errors - base_o, NPIX);
      end
      repeat (20) @(negedge Clk50);
      assertions++;
      if (done_count - base_d != 1 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL overrun_restart: pulses=%0d busy=%b, expected 1,0", done_count - base_d, busy);
      end
   endtask

   task automatic test_abort();
      int base_w, base_d;
      bit ok;
      sprite_mode = 1'b0;
      start_frame();
      wait_accept(2000, ok);
      assertions++;
      if (!ok) begin
         failures++; $display("[TB] FAIL abort_reach: address 2000 never written, expected it");
      end
      #1 Reset_n = 1'b0;
      #1;
      assertions++;
      if (fb_we !== 1'b0 || busy !== 1'b0 || fb_addr !== 19'd0) begin
         failures++; $display("[TB] FAIL abort_async: we=%b busy=%b addr=%0d, expected 0,0,0", fb_we, busy, fb_addr);
      end
      repeat (3) @(negedge Clk50);
      @(posedge Clk50);
      #1 Reset_n = 1'b1;
      repeat (5) @(negedge Clk50);
      base_w = write_count; base_d = done_count;
      start_frame();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk50);
         if (fb_we) begin
            ok = 1'b1;
            break;
         end
      end
      assertions++;
      if (!ok || fb_addr !== 19'd0) begin
         failures++; $display("[TB] FAIL abort_restart: seen=%b addr=%0d, expected 1,0", ok, fb_addr);
      end
      wait_done(base_d, ok);
      assertions++;
      if (!ok || write_count - base_w != NPIX) begin
         failures++; $display("[TB] FAIL abort_count: done=%b writes=%0d, expected 1,%0d", ok, write_count - base_w, NPIX);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_background_frame();
      test_sprite_priority();
      test_stall();
      test_overrun();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
